// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: stall/flush controller for the 5-stage pipeline (load-use, multdiv wait, taken branch).
// Latency: controls are combinational from state+inputs; a mul/div holds the pipe until md_ready or MD_TIMEOUT WAIT cycles.
// Backpressure: stalls PC/F/D/D/X upstream while multdiv is busy; md_ready is ignored outside WAIT.
//
// Ports:
//   clock, reset                : rising-edge clock, synchronous active-high reset
//   fd_insn, dx_insn            : instructions held in the F/D and D/X latches
//   branch_taken                : X stage resolved a taken branch/jump this cycle
//   md_ready, md_exception      : multdiv result valid / exception (qualified by md_ready)
//   stall_pc/fd/dx              : hold PC and latches
//   bubble_dx, bubble_xm        : load nop into D/X, X/M
//   flush_fd                    : load nop into F/D
//   md_ctrl_mult/div            : one-cycle multdiv start pulses
//   md_result_valid, md_error   : X stage takes multdiv result; error = exception or timeout
//   md_timeout                  : sticky timeout flag, cleared only by reset
//   stall_cycles (optional)     : saturating count of stall_pc cycles, present when
//                                 HAZ_PERF_CNT_EN is defined
module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  input  logic        branch_taken,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        bubble_dx,
  output logic        bubble_xm,
  output logic        flush_fd,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        md_result_valid,
  output logic        md_error,
  output logic        md_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;

  // Instruction field decode
  logic [4:0] dx_op, dx_rd, dx_aluop;
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, fd_aluop;
  logic       dx_is_mul, dx_is_div, dx_is_lw;
  logic       fd_uses_rs, fd_uses_rt, fd_uses_rd;
  logic       load_use;

  assign dx_op    = dx_insn[31:27];
  assign dx_rd    = dx_insn[26:22];
  assign dx_aluop = dx_insn[6:2];
  assign fd_op    = fd_insn[31:27];
  assign fd_rd    = fd_insn[26:22];
  assign fd_rs    = fd_insn[21:17];
  assign fd_rt    = fd_insn[16:12];
  assign fd_aluop = fd_insn[6:2];

  assign dx_is_mul = (dx_op == OP_R) && (dx_aluop == ALU_MUL);
  assign dx_is_div = (dx_op == OP_R) && (dx_aluop == ALU_DIV);
  assign dx_is_lw  = (dx_op == OP_LW);

  assign fd_uses_rs = (fd_op == OP_R) || (fd_op == OP_ADDI) || (fd_op == OP_LW) ||
                      (fd_op == OP_SW) || (fd_op == OP_BNE) || (fd_op == OP_BLT);
  // Shifts (aluop 0010x) take a shift amount instead of rt.
  assign fd_uses_rt = (fd_op == OP_R) && (fd_aluop[4:1] != 4'b0010);
  // sw's rd is store data, covered by the W->M bypass, so it is not listed here.
  assign fd_uses_rd = (fd_op == OP_BNE) || (fd_op == OP_BLT) || (fd_op == OP_JR);

  assign load_use = dx_is_lw && (dx_rd != 5'd0) &&
                    ((fd_uses_rs && (fd_rs == dx_rd)) ||
                     (fd_uses_rt && (fd_rt == dx_rd)) ||
                     (fd_uses_rd && (fd_rd == dx_rd)));

  // Fields that take no part in hazard detection.
  logic unused_fields;
  assign unused_fields = ^{dx_insn[21:7], dx_insn[1:0], fd_insn[11:7], fd_insn[1:0]};

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    tmo_d           = tmo_q;
    stall_pc        = 1'b0;
    stall_fd        = 1'b0;
    stall_dx        = 1'b0;
    bubble_dx       = 1'b0;
    bubble_xm       = 1'b0;
    flush_fd        = 1'b0;
    md_ctrl_mult    = 1'b0;
    md_ctrl_div     = 1'b0;
    md_result_valid = 1'b0;
    md_error        = 1'b0;
    md_timeout      = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (branch_taken) begin
          flush_fd  = 1'b1;
          bubble_dx = 1'b1;
        end else if (dx_is_mul || dx_is_div) begin
          md_ctrl_mult = dx_is_mul;
          md_ctrl_div  = dx_is_div;
          stall_pc     = 1'b1;
          stall_fd     = 1'b1;
          stall_dx     = 1'b1;
          bubble_xm    = 1'b1;
          cnt_d        = '0;
          state_d      = S_WAIT;
        end else if (load_use) begin
          stall_pc  = 1'b1;
          stall_fd  = 1'b1;
          bubble_dx = 1'b1;
        end
      end
      S_WAIT: begin
        stall_pc  = 1'b1;
        stall_fd  = 1'b1;
        stall_dx  = 1'b1;
        bubble_xm = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (md_ready) begin
          err_d   = md_exception;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Stalls drop so the mul/div leaves X with its result this cycle.
        md_result_valid = 1'b1;
        md_error        = err_q;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Quiet every control while reset is held so nothing launches from stale latch contents.
    if (reset) begin
      stall_pc        = 1'b0;
      stall_fd        = 1'b0;
      stall_dx        = 1'b0;
      bubble_dx       = 1'b0;
      bubble_xm       = 1'b0;
      flush_fd        = 1'b0;
      md_ctrl_mult    = 1'b0;
      md_ctrl_div     = 1'b0;
      md_result_valid = 1'b0;
      md_error        = 1'b0;
      md_timeout      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_pc && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard cases, multdiv transactions with
// chosen latencies, timeout boundary, reset mid-wait, and randomized traffic.
module tb_pipeline_hazard_ctrl;
  localparam int T = 8;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;

  // Output vector order: stall_pc stall_fd stall_dx bubble_dx bubble_xm flush_fd
  //                      mult div result_valid error timeout
  localparam logic [10:0] V_LU   = 11'b11010000000;
  localparam logic [10:0] V_BR   = 11'b00010100000;
  localparam logic [10:0] V_WAIT = 11'b11101000000;
  localparam logic [10:0] V_MUL  = 11'b11101010000;
  localparam logic [10:0] V_DIV  = 11'b11101001000;
  localparam logic [10:0] V_DONE = 11'b00000000100;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fd_insn, dx_insn;
  logic        branch_taken, md_ready, md_exception;
  logic        stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd;
  logic        md_ctrl_mult, md_ctrl_div, md_result_valid, md_error, md_timeout;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif
  logic [10:0] obs;

  int          total = 0;
  int          bad = 0;
  logic        tmo_m;      // expected sticky timeout
  int unsigned stall_m;    // expected stall_pc cycle count since reset

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(T), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_dx(stall_dx),
    .bubble_dx(bubble_dx), .bubble_xm(bubble_xm), .flush_fd(flush_fd),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_result_valid(md_result_valid), .md_error(md_error), .md_timeout(md_timeout)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  assign obs = {stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd,
                md_ctrl_mult, md_ctrl_div, md_result_valid, md_error, md_timeout};

  function automatic logic [31:0] mk_r(input logic [4:0] rd, rs, rt, alu);
    return {OP_R, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] op, rd, rs);
    return {op, rd, rs, 17'd4};
  endfunction

  // Registers an instruction reads in decode, from the ISA rules.
  function automatic bit reads_reg(input logic [31:0] insn, input logic [4:0] r);
    logic [4:0] op;
    bit rs_used, rt_used, rd_used;
    op = insn[31:27];
    rs_used = op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT};
    rt_used = (op == OP_R) && !(insn[6:2] inside {5'b00100, 5'b00101});
    rd_used = op inside {OP_BNE, OP_BLT, OP_JR};
    return (rs_used && insn[21:17] == r) || (rt_used && insn[16:12] == r) ||
           (rd_used && insn[26:22] == r);
  endfunction

  // Expected controls while idle with a non-multdiv instruction in D/X.
  function automatic logic [10:0] exp_idle(input logic [31:0] dx, fd, input logic br);
    if (br) return V_BR;
    if (dx[31:27] == OP_LW && dx[26:22] != 5'd0 && reads_reg(fd, dx[26:22])) return V_LU;
    return 11'd0;
  endfunction

  function automatic logic [31:0] rand_insn(input bit allow_md);
    logic [31:0] w;
    logic [4:0]  op, alu;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: op = OP_R;
      3: op = OP_LW;
      4: op = OP_SW;
      5: op = OP_ADDI;
      6: op = OP_BNE;
      7: op = OP_BLT;
      8: op = OP_JR;
      default: op = 5'b00001;
    endcase
    case ($urandom_range(0, 7))
      0: alu = 5'b00000;
      1: alu = 5'b00001;
      2: alu = 5'b00010;
      3: alu = 5'b00100;
      4: alu = 5'b00101;
      5: alu = 5'b01000;
      6: alu = allow_md ? 5'b00110 : 5'b00011;
      default: alu = allow_md ? 5'b00111 : 5'b01001;
    endcase
    w[31:27] = op;
    w[26:22] = {2'b00, 3'($urandom)};
    w[21:17] = {2'b00, 3'($urandom)};
    w[16:12] = {2'b00, 3'($urandom)};
    if (op == OP_R) w[6:2] = alu;
    return w;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dx_insn = mk_r(5'd5, 5'd1, 5'd2, 5'b00110);
    fd_insn = $urandom;
    branch_taken = 1'b0;
    md_ready = 1'b1;
    md_exception = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    tmo_m = 1'b0;
    stall_m = 0;
    dx_insn = 32'd0;
    @(negedge clock);
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b", obs, 11'd0);
    end
`ifdef HAZ_PERF_CNT_EN
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles);
    end
`endif
    md_ready = 1'b0;
    md_exception = 1'b0;
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [31:0] dxs[12];
    logic [31:0] fds[12];
    logic [10:0] exps[12];
    logic [31:0] lw3;
    lw3 = mk_i(OP_LW, 5'd3, 5'd1);
    dxs[0]  = lw3;                     fds[0]  = mk_r(5'd4, 5'd3, 5'd5, 5'd0);  exps[0]  = V_LU;
    dxs[1]  = 32'd0;                   fds[1]  = mk_r(5'd4, 5'd3, 5'd5, 5'd0);  exps[1]  = 11'd0;
    dxs[2]  = lw3;                     fds[2]  = mk_i(OP_SW, 5'd3, 5'd6);       exps[2]  = 11'd0;
    dxs[3]  = lw3;                     fds[3]  = mk_i(OP_SW, 5'd6, 5'd3);       exps[3]  = V_LU;
    dxs[4]  = mk_i(OP_LW, 5'd0, 5'd1); fds[4]  = mk_r(5'd4, 5'd0, 5'd5, 5'd0);  exps[4]  = 11'd0;
    dxs[5]  = lw3;                     fds[5]  = mk_r(5'd4, 5'd1, 5'd3, 5'd4);  exps[5]  = 11'd0;
    dxs[6]  = lw3;                     fds[6]  = mk_r(5'd4, 5'd1, 5'd3, 5'd1);  exps[6]  = V_LU;
    dxs[7]  = lw3;                     fds[7]  = mk_i(OP_BNE, 5'd3, 5'd1);      exps[7]  = V_LU;
    dxs[8]  = lw3;                     fds[8]  = mk_i(OP_JR, 5'd3, 5'd0);       exps[8]  = V_LU;
    dxs[9]  = lw3;                     fds[9]  = mk_i(OP_ADDI, 5'd3, 5'd1);     exps[9]  = 11'd0;
    dxs[10] = lw3;                     fds[10] = mk_i(OP_LW, 5'd5, 5'd3);       exps[10] = V_LU;
    dxs[11] = mk_r(5'd3, 5'd1, 5'd2, 5'd0); fds[11] = mk_r(5'd4, 5'd3, 5'd5, 5'd0); exps[11] = 11'd0;
    branch_taken = 1'b0;
    md_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      dx_insn = dxs[i];
      fd_insn = fds[i];
      @(negedge clock);
      total++;
      if (obs !== (exps[i] | {10'd0, tmo_m})) begin
        bad++;
        $display("FAIL load_use[%0d]: got %b want %b", i, obs, exps[i] | {10'd0, tmo_m});
      end
      stall_m += exps[i][10];
      next_cycle();
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 4; i++) begin
      branch_taken = (i % 2 == 0);
      dx_insn = branch_taken ? mk_i(OP_BNE, 5'd2, 5'd1) : 32'd0;
      fd_insn = mk_r(5'd4, 5'd2, 5'd5, 5'd0);
      @(negedge clock);
      total++;
      if (obs !== ((branch_taken ? V_BR : 11'd0) | {10'd0, tmo_m})) begin
        bad++;
        $display("FAIL branch[%0d]: got %b want %b", i, obs,
                 (branch_taken ? V_BR : 11'd0) | {10'd0, tmo_m});
      end
      next_cycle();
    end
    branch_taken = 1'b0;
  endtask

  // One multdiv transaction: start cycle, WAIT cycles until md_ready arrives
  // lat cycles after the start or the timeout fires, then the DONE cycle.
  task automatic test_md(input bit is_div, input int lat, input bit exc, input string name);
    logic [10:0] e;
    bit          timed;
    timed = 1'b0;
    dx_insn = mk_r(5'd5, 5'd1, 5'd2, is_div ? 5'b00111 : 5'b00110);
    fd_insn = rand_insn(1'b1);
    branch_taken = 1'b0;
    md_ready = 1'($urandom);
    md_exception = 1'($urandom);
    e = (is_div ? V_DIV : V_MUL) | {10'd0, tmo_m};
    @(negedge clock);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL %s_start: got %b want %b", name, obs, e);
    end
    stall_m += e[10];
    next_cycle();
    for (int k = 1; k <= T; k++) begin
      md_ready = (k == lat);
      md_exception = (k == lat) ? exc : 1'($urandom);
      fd_insn = rand_insn(1'b1);
      e = V_WAIT | {10'd0, tmo_m};
      @(negedge clock);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s_wait%0d: got %b want %b", name, k, obs, e);
      end
      stall_m += e[10];
      next_cycle();
      if (k == lat) break;
      if (k == T) begin
        timed = 1'b1;
        tmo_m = 1'b1;
      end
    end
    md_ready = 1'($urandom);
    md_exception = 1'($urandom);
    e = V_DONE | {9'd0, (timed ? 1'b1 : exc), tmo_m};
    @(negedge clock);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL %s_done: got %b want %b", name, obs, e);
    end
    stall_m += e[10];
    next_cycle();
    md_ready = 1'b0;
  endtask

  task automatic test_idle_cycles(input int n, input string name);
    logic [10:0] e;
    for (int i = 0; i < n; i++) begin
      dx_insn = rand_insn(1'b0);
      fd_insn = rand_insn(1'b1);
      branch_taken = ($urandom_range(0, 3) == 0);
      md_ready = 1'($urandom);
      md_exception = 1'($urandom);
      e = exp_idle(dx_insn, fd_insn, branch_taken) | {10'd0, tmo_m};
      @(negedge clock);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s[%0d]: got %b want %b dx=%h fd=%h", name, i, obs, e, dx_insn, fd_insn);
      end
      stall_m += e[10];
      next_cycle();
    end
    branch_taken = 1'b0;
    md_ready = 1'b0;
  endtask

  task automatic test_timeout();
    test_md(1'b1, T, 1'b0, "div_last_cycle");
    test_md(1'b1, 1000, 1'b0, "div_timeout");
    test_idle_cycles(3, "sticky_idle");
    test_md(1'b0, 3, 1'b0, "mul_after_timeout");
  endtask

  task automatic test_back_to_back();
    test_md(1'b0, 1, 1'b0, "b2b_mul");
    test_md(1'b1, 2, 1'b1, "b2b_div");
    test_md(1'b0, 3, 1'b0, "b2b_mul2");
  endtask

  task automatic test_reset_mid_wait();
    dx_insn = mk_r(5'd5, 5'd1, 5'd2, 5'b00110);
    md_ready = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    tmo_m = 1'b0;
    stall_m = 0;
    dx_insn = 32'd0;
    fd_insn = 32'd0;
    for (int i = 0; i < 3; i++) begin
      md_ready = (i > 0);
      md_exception = 1'b1;
      @(negedge clock);
      total++;
      if (obs !== 11'd0) begin
        bad++;
        $display("FAIL reset_mid_wait[%0d]: got %b want %b", i, obs, 11'd0);
      end
`ifdef HAZ_PERF_CNT_EN
      if (i == 0) begin
        total++;
        if (stall_cycles !== 32'd0) begin
          bad++;
          $display("FAIL reset_mid_wait_cnt: got %0d want 0", stall_cycles);
        end
      end
`endif
      next_cycle();
    end
    md_ready = 1'b0;
  endtask

  task automatic test_random_md();
    for (int i = 0; i < 12; i++) begin
      test_md(1'($urandom), $urandom_range(1, T + 3), 1'($urandom), "rand_md");
      test_idle_cycles($urandom_range(0, 2), "rand_gap");
    end
  endtask

  task automatic test_perf_count();
`ifdef HAZ_PERF_CNT_EN
    @(negedge clock);
    total++;
    if (stall_cycles !== stall_m) begin
      bad++;
      $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, stall_m);
    end
    next_cycle();
`endif
  endtask

  initial begin
    reset = 1'b1;
    dx_insn = 32'd0;
    fd_insn = 32'd0;
    branch_taken = 1'b0;
    md_ready = 1'b0;
    md_exception = 1'b0;
    tmo_m = 1'b0;
    stall_m = 0;
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_md(1'b0, 4, 1'b0, "mult");
    test_md(1'b0, 2, 1'b1, "mult_exc");
    test_idle_cycles(150, "rand_idle");
    test_back_to_back();
    test_perf_count();
    test_timeout();
    test_reset_mid_wait();
    test_random_md();
    test_perf_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout want completion");
    $fatal(1);
  end

endmodule
